// File: rtl/vga_pkg.sv
// Shared VGA scan-out definitions: default 640x480@60 timing, RGB444 colour type
// and the colour-bar test pattern table.
package vga_pkg;

  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam int H_TOTAL = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int FB_LAST = H_VIS_DEF * V_VIS_DEF - 1;

  // Counters are wide enough for totals up to 2047 and always expose h[9:7] for bars.
  localparam int CNT_W  = 11;
  localparam int ADDR_W = 19;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam rgb444_t BLACK = 12'h000;

  function automatic rgb444_t bar_colour(input logic [2:0] idx);
    rgb444_t c;
    case (idx)
      3'd0:    c = 12'hFFF;
      3'd1:    c = 12'hFF0;
      3'd2:    c = 12'h0FF;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'hF0F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider and h/v raster counters with visible, sync and frame-wrap
// decodes for the current (h,v) slot.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_h,
  output logic [CNT_W-1:0] o_v,
  output logic             o_visible,
  output logic             o_hsync_n,
  output logic             o_vsync_n,
  output logic             o_frame_wrap
);

  localparam logic [CNT_W-1:0] L_H_VIS   = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] L_HS_BEG  = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] L_HS_END  = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] L_H_LAST  = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] L_V_VIS   = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] L_VS_BEG  = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] L_VS_END  = CNT_W'(V_VIS + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] L_V_LAST  = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);

  logic [1:0]       r_div;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic             w_tick;
  logic             w_h_last;
  logic             w_v_last;

  assign w_tick   = (r_div == 2'd3);
  assign w_h_last = (r_h == L_H_LAST);
  assign w_v_last = (r_v == L_V_LAST);

  // Free-running divide-by-4 pixel clock enable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div <= 2'd0;
    end else begin
      r_div <= r_div + 2'd1;
    end
  end

  // Raster position advances once per pixel tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + CNT_W'(1);
      end else begin
        r_h <= r_h + CNT_W'(1);
      end
    end
  end

  assign o_tick       = w_tick;
  assign o_h          = r_h;
  assign o_v          = r_v;
  assign o_visible    = (r_h < L_H_VIS) && (r_v < L_V_VIS);
  assign o_hsync_n    = !((r_h >= L_HS_BEG) && (r_h < L_HS_END));
  assign o_vsync_n    = !((r_v >= L_VS_BEG) && (r_v < L_VS_END));
  assign o_frame_wrap = w_tick && w_h_last && w_v_last;

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: framebuffer address generation, per-frame test-pattern select and
// registered colour/sync outputs, one pixel slot behind the raster counters.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic              test_en,
  output logic [ADDR_W-1:0] raddr_vga,
  input  logic [11:0]       rdata_vga,
  output logic [3:0]        VGA_R,
  output logic [3:0]        VGA_G,
  output logic [3:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              frame_start
);

  // Address must be driven a full slot ahead of the sampling tick, so latency > 3 cannot work.
  if ((RD_LAT < 1) || (RD_LAT > 3)) begin : g_bad_rd_lat
    $error("vga_scanout: RD_LAT must be in 1..3");
  end

  localparam logic [ADDR_W-1:0] L_FB_LAST = ADDR_W'(H_VIS * V_VIS - 1);

  logic             w_tick;
  logic [CNT_W-1:0] w_h;
  logic [CNT_W-1:0] w_v;
  logic             w_visible;
  logic             w_hsync_n;
  logic             w_vsync_n;
  logic             w_frame_wrap;
  rgb444_t          w_pix_colour;

  logic [ADDR_W-1:0] r_addr;
  logic              r_test_mode;
  rgb444_t           r_colour;
  logic              r_hs;
  logic              r_vs;
  logic              r_frame_start;

  vga_timing #(
    .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
  ) u_timing (
    .i_clk        (CLK100MHZ),
    .i_rst        (rst),
    .o_tick       (w_tick),
    .o_h          (w_h),
    .o_v          (w_v),
    .o_visible    (w_visible),
    .o_hsync_n    (w_hsync_n),
    .o_vsync_n    (w_vsync_n),
    .o_frame_wrap (w_frame_wrap)
  );

  // Colour for the current slot: memory or bar when visible, black in blanking.
  always_comb begin
    w_pix_colour = BLACK;
    if (w_visible) begin
      if (r_test_mode) begin
        w_pix_colour = bar_colour(w_h[9:7]);
      end else begin
        w_pix_colour = rgb444_t'(rdata_vga);
      end
    end else begin
      w_pix_colour = BLACK;
    end
  end

  // Blanking holds the address of the next visible pixel; the last pixel is never exceeded.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
    end else if (w_tick) begin
      if (w_frame_wrap) begin
        r_addr <= '0;
      end else if (w_visible && (r_addr != L_FB_LAST)) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  // Test mode only changes between frames so a frame is never half bars.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      r_test_mode <= 1'b0;
    end else if (w_frame_wrap) begin
      r_test_mode <= test_en;
    end
  end

  // Output stage: colour and sync for the slot just closed, co-registered.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      r_colour <= BLACK;
      r_hs     <= 1'b1;
      r_vs     <= 1'b1;
    end else if (w_tick) begin
      r_colour <= w_pix_colour;
      r_hs     <= w_hsync_n;
      r_vs     <= w_vsync_n;
    end
  end

  // Single-cycle frame marker following the wrap tick.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_wrap;
    end
  end

  assign raddr_vga   = r_addr;
  assign VGA_R       = r_colour.r;
  assign VGA_G       = r_colour.g;
  assign VGA_B       = r_colour.b;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign frame_start = r_frame_start;

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Scan-out stage that sits directly downstream of `memory_controller`'s VGA read port. It generates 640x480 @ 60 Hz VGA timing from the 100 MHz system clock using a divide-by-4 pixel tick. It drives `raddr_vga` and consumes `rdata_vga` (12-bit RGB444), registering colour and sync onto the board's VGA pins. A frame-aligned colour-bar test pattern is selectable.

## Interface
Parameters:
- `RD_LAT`, default 1: `memory_controller` read latency in sys_clk cycles from `raddr_vga` to valid `rdata_vga`; legal range 1..3, elaboration error otherwise.
- `H_VIS/H_FP/H_SYNC/H_BP`, default 640/16/96/48: horizontal timing in pixels.
- `V_VIS/V_FP/V_SYNC/V_BP`, default 480/10/2/33: vertical timing in lines.

Ports:
- `CLK100MHZ` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous and active-high.
- `test_en` in 1: selects colour bars instead of memory data; sampled once per frame.
- `raddr_vga` out 19: framebuffer read address, y*640+x.
- `rdata_vga` in 12: read data, {R[3:0],G[3:0],B[3:0]}.
- `VGA_R/VGA_G/VGA_B` out 4 each: colour outputs.
- `VGA_HS` out 1: horizontal sync, active-low.
- `VGA_VS` out 1: vertical sync, active-low.
- `frame_start` out 1: one-cycle pulse at start of each frame, for ALU/camera coordination.

## Operation
- Divider: 2-bit `div` counts 0..3 every cycle; `tick` = (div==3).
- Counters advance only on tick edges.
  - `h` counts 0..799 and wraps to 0.
  - `v` increments on `h` wrap, counts 0..524, wraps to 0.
- Visible region: h<640 and v<480.
- Sync regions:
  - HS low for h in 656..751.
  - VS low for v in 490..491.
- Address counter:
  - `addr` increments on a tick when the current pixel is visible and addr≠307199.
  - `addr` resets to 0 on the frame-wrap tick (h==799, v==524).
  - Blanking holds the next pixel's address, so `raddr_vga` is never above 307199.
  - `raddr_vga` = `addr` (registered).
- Output stage updates on every tick edge from current h, v and `rdata_vga`:
  - Visible: colour = `rdata_vga`, or the test bar when `test_mode`=1.
  - Blanking: all colour bits 0.
  - HS/VS take the sync values for the same (h,v).
- Test bars: index = h[9:7] (0..4). Colours: FFF, FF0, 0FF, 0F0, F0F.
- `test_mode` register: loads `test_en` on the frame-wrap tick only. Mid-frame changes to `test_en` take effect next frame.
- `frame_start`: high for exactly the one cycle after the frame-wrap tick edge.

## Timing
- Reset values:
  - div, h, v, addr, `raddr_vga`, `test_mode`: 0.
  - VGA_R/G/B: 0.
  - VGA_HS, VGA_VS: 1.
  - `frame_start`: 0.
- First tick occurs in the 4th cycle after `rst` deasserts.
- `raddr_vga` for pixel (h,v) is stable for the 4-cycle slot in which the counters hold (h,v). `RD_LAT`≤3 guarantees `rdata_vga` is valid at the closing tick edge.
- Pixel (h,v) appears on all VGA outputs one pixel slot (4 cycles) after its counter slot. Colour and sync are co-aligned with zero skew.
- Line period = 3200 cycles; frame period = 1,680,000 cycles.
- Reset asserted mid-frame: all state returns to reset values immediately (async). Scan restarts at (0,0) with no `frame_start` pulse for the aborted frame.
- No backpressure: `rdata_vga` is sampled unconditionally.

## Structure
- Package `vga_pkg`:
  - timing constants and derived totals (H_TOTAL=800, V_TOTAL=525, FB_LAST=307199);
  - RGB444 colour type and the 5-entry bar table.
- Sub-module `vga_timing`: divider, h/v counters, tick, visible, hsync, vsync, frame_wrap.
- `vga_scanout` holds the address counter, test-mode register and output registers.

## Test plan
- Reset release, `rdata_vga`=ABC, `test_en`=0 → first `VGA_HS` falling edge at cycle 4·657 after reset. `VGA_R/G/B`=A/B/C from cycle 8 for 640 slots, then 0.
- Full frame → `VGA_VS` low for exactly 2·3200 cycles starting at line 490. `frame_start` pulses every 1,680,000 cycles. `raddr_vga` max 307199, never higher.
- Memory model with `RD_LAT`=3 returning data=addr[11:0] → pixel (5,2) output shows 12'h505 (1285 mod 4096). No colour/sync misalignment.
- `test_en` raised at line 100 → memory data continues to frame end. Next frame shows bars FFF at h=0, FF0 at h=128, F0F at h=512..639.
- `rst` pulsed mid-line 200 → outputs at reset values within the same cycle. After release, `raddr_vga` restarts at 0 and the first frame completes normally.
- Blanking, `rdata_vga`=FFF → colour outputs remain 0 throughout all h≥640 or v≥480 slots.
